// File: rtl/jt10_mix_pkg.sv
// Shared definitions for the jt10 accumulator/mixer: algorithm codes, slot-code
// width and the saturation helpers used by each output side.
package jt10_mix_pkg;

    localparam int SLOT_W = 5;

    typedef enum logic [2:0] {
        ALG_0 = 3'd0,
        ALG_1 = 3'd1,
        ALG_2 = 3'd2,
        ALG_3 = 3'd3,
        ALG_4 = 3'd4,
        ALG_5 = 3'd5,
        ALG_6 = 3'd6,
        ALG_7 = 3'd7
    } alg_e;

    // Carrier operators are the only ones that reach the mixer.
    function automatic logic fm_enable(input logic [2:0] alg, input logic s1,
                                       input logic s2, input logic s4);
        logic en;
        case (alg)
            ALG_4:        en = s2 | s4;
            ALG_5, ALG_6: en = ~s1;
            ALG_7:        en = 1'b1;
            default:      en = s4;
        endcase
        return en;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    function automatic logic saturates(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/jt10_mix_side.sv
// One output side: frame accumulator, saturated sample register and sticky clip flag.
module jt10_mix_side
    import jt10_mix_pkg::*;
#(
    parameter int WOUT = 16,
    parameter int WACC = 21
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic                   zero,
    input  logic                   clip_clr,
    input  logic signed [WACC-1:0] add,
    output logic signed [WOUT-1:0] out,
    output logic                   clip
);

    logic signed [WACC-1:0] acc_r;
    logic signed [WOUT-1:0] out_r;
    logic                   clip_r;
    logic signed [63:0]     acc_wide_s;
    logic signed [63:0]     sat_s;
    logic                   ovf_s;
    logic                   clip_set_s;

    // Saturated view of the finished frame sum.
    always_comb begin
        acc_wide_s = 64'(acc_r);
        sat_s      = saturate(acc_wide_s, WOUT);
        ovf_s      = saturates(acc_wide_s, WOUT);
        clip_set_s = clk_en & zero & ovf_s;
    end

    // Accumulate, and at frame start publish the sum and restart with this slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= '0;
            out_r <= '0;
        end else if (clk_en) begin
            if (zero) begin
                out_r <= sat_s[WOUT-1:0];
                acc_r <= add;
            end else begin
                acc_r <= acc_r + add;
            end
        end
    end

    // Sticky clip flag; a new saturation beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clip_r <= 1'b0;
        end else if (clip_set_s) begin
            clip_r <= 1'b1;
        end else if (clip_clr) begin
            clip_r <= 1'b0;
        end
    end

    assign out  = out_r;
    assign clip = clip_r;

endmodule

// File: rtl/jt10_acc_mix.sv
// Stereo FM accumulator with external sample injection into fixed slots.
module jt10_acc_mix
    import jt10_mix_pkg::*;
#(
    parameter int                       WOP      = 14,
    parameter int                       WOUT     = 16,
    parameter int                       NEXT     = 2,
    parameter logic [SLOT_W*NEXT-1:0]   EXT_SLOT = {5'd6, 5'd2},
    parameter logic [4*NEXT-1:0]        EXT_SH   = {4'hE, 4'h4}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic signed [WOP-1:0]  op_result,
    input  logic [1:0]             rl,
    input  logic                   zero,
    input  logic                   s1_enters,
    input  logic                   s2_enters,
    input  logic                   s4_enters,
    input  logic [2:0]             alg,
    input  logic [2:0]             cur_ch,
    input  logic [1:0]             cur_op,
    input  logic [16*NEXT-1:0]     ext_l,
    input  logic [16*NEXT-1:0]     ext_r,
    input  logic [NEXT-1:0]        ext_stb,
    input  logic [NEXT-1:0]        mix_en,
    input  logic                   clip_clr,
    output logic signed [WOUT-1:0] left,
    output logic signed [WOUT-1:0] right,
    output logic                   sample_stb,
    output logic                   clip_l,
    output logic                   clip_r
);

    localparam int WACC = WOUT + 5;

    logic signed [15:0]     hold_l_r [NEXT];
    logic signed [15:0]     hold_r_r [NEXT];
    logic                   sample_stb_r;
    logic [SLOT_W-1:0]      slot_s;
    logic [NEXT-1:0]        hit_vec_s;
    logic                   hit_s;
    logic                   ext_en_s;
    logic signed [WACC-1:0] ext_l_s;
    logic signed [WACC-1:0] ext_r_s;
    logic signed [WACC-1:0] add_l_s;
    logic signed [WACC-1:0] add_r_s;

    function automatic logic signed [WACC-1:0] shift_ext(input logic signed [15:0] v,
                                                        input logic [3:0] sh);
        logic signed [WACC-1:0] w;
        logic [3:0]             mag;
        w   = WACC'(v);
        mag = 4'd0 - sh;
        if (sh[3]) begin
            return w >>> mag;
        end else begin
            return w <<< sh;
        end
    endfunction

    // Hold registers follow their strobes regardless of slot timing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NEXT; i++) begin
            if (!rst_n) begin
                hold_l_r[i] <= '0;
                hold_r_r[i] <= '0;
            end else if (ext_stb[i]) begin
                hold_l_r[i] <= ext_l[16*i +: 16];
                hold_r_r[i] <= ext_r[16*i +: 16];
            end
        end
    end

    // Scan from the top index down so the lowest matching input wins.
    always_comb begin
        slot_s    = {cur_op, cur_ch};
        hit_vec_s = '0;
        ext_en_s  = 1'b0;
        ext_l_s   = '0;
        ext_r_s   = '0;
        for (int i = NEXT - 1; i >= 0; i--) begin
            hit_vec_s[i] = (slot_s == EXT_SLOT[SLOT_W*i +: SLOT_W]);
            ext_en_s     = hit_vec_s[i] ? mix_en[i] : ext_en_s;
            ext_l_s      = hit_vec_s[i] ? shift_ext(hold_l_r[i], EXT_SH[4*i +: 4]) : ext_l_s;
            ext_r_s      = hit_vec_s[i] ? shift_ext(hold_r_r[i], EXT_SH[4*i +: 4]) : ext_r_s;
        end
        hit_s = |hit_vec_s;
    end

    // Per-slot contribution; an external slot replaces the FM operator entirely.
    always_comb begin
        add_l_s = '0;
        add_r_s = '0;
        if (hit_s) begin
            add_l_s = ext_en_s ? ext_l_s : '0;
            add_r_s = ext_en_s ? ext_r_s : '0;
        end else if (fm_enable(alg, s1_enters, s2_enters, s4_enters)) begin
            add_l_s = rl[1] ? WACC'(op_result) : '0;
            add_r_s = rl[0] ? WACC'(op_result) : '0;
        end else begin
            add_l_s = '0;
            add_r_s = '0;
        end
    end

    // Strobe accompanies the sample published at a frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_stb_r <= 1'b0;
        end else begin
            sample_stb_r <= clk_en & zero;
        end
    end

    assign sample_stb = sample_stb_r;

    jt10_mix_side #(
        .WOUT (WOUT),
        .WACC (WACC)
    ) u_side_l (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .zero     (zero),
        .clip_clr (clip_clr),
        .add      (add_l_s),
        .out      (left),
        .clip     (clip_l)
    );

    jt10_mix_side #(
        .WOUT (WOUT),
        .WACC (WACC)
    ) u_side_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .zero     (zero),
        .clip_clr (clip_clr),
        .add      (add_r_s),
        .out      (right),
        .clip     (clip_r)
    );

endmodule

// File: tb/tb_jt10_acc_mix.sv
// Self-checking bench for jt10_acc_mix: a slot-level model feeds a scoreboard of
// expected frame samples, plus directed checks of the headline values.
module tb_jt10_acc_mix;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clk_en;
    logic signed [13:0] op_result;
    logic [1:0]         rl;
    logic               zero;
    logic               s1_enters;
    logic               s2_enters;
    logic               s4_enters;
    logic [2:0]         alg;
    logic [2:0]         cur_ch;
    logic [1:0]         cur_op;
    logic [31:0]        ext_l;
    logic [31:0]        ext_r;
    logic [1:0]         ext_stb;
    logic [1:0]         mix_en;
    logic               clip_clr;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               sample_stb;
    logic               clip_l;
    logic               clip_r;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int l;
        int r;
    } exp_t;
    exp_t exp_q[$];

    int m_acc_l, m_acc_r, m_left, m_right;
    bit m_clip_l, m_clip_r;
    int m_hold_l[2];
    int m_hold_r[2];

    always #5 clk = ~clk;

    jt10_acc_mix dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .op_result  (op_result),
        .rl         (rl),
        .zero       (zero),
        .s1_enters  (s1_enters),
        .s2_enters  (s2_enters),
        .s4_enters  (s4_enters),
        .alg        (alg),
        .cur_ch     (cur_ch),
        .cur_op     (cur_op),
        .ext_l      (ext_l),
        .ext_r      (ext_r),
        .ext_stb    (ext_stb),
        .mix_en     (mix_en),
        .clip_clr   (clip_clr),
        .left       (left),
        .right      (right),
        .sample_stb (sample_stb),
        .clip_l     (clip_l),
        .clip_r     (clip_r)
    );

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        else if (v < -32768) return -32768;
        else return v;
    endfunction

    function automatic bit fm_on(input logic [2:0] a, input logic s1, input logic s2,
                                 input logic s4);
        case (a)
            3'd4:       return s2 | s4;
            3'd5, 3'd6: return !s1;
            3'd7:       return 1'b1;
            default:    return s4;
        endcase
    endfunction

    task automatic model_reset();
        m_acc_l = 0; m_acc_r = 0; m_left = 0; m_right = 0;
        m_clip_l = 1'b0; m_clip_r = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_hold_l[i] = 0;
            m_hold_r[i] = 0;
        end
        exp_q.delete();
    endtask

    // One slot: drive, predict, clock, then compare against the scoreboard.
    task automatic step(input logic [1:0] op, input logic [2:0] ch, input logic z,
                        input logic en);
        int   cl, cr;
        bit   ovl, ovr, exp_stb;
        exp_t e;
        cur_op = op; cur_ch = ch; zero = z; clk_en = en;
        s1_enters = (op == 2'd0);
        s2_enters = (op == 2'd2);
        s4_enters = (op == 2'd3);
        cl = 0; cr = 0;
        if (op == 2'd0 && ch == 3'd2) begin
            if (mix_en[0]) begin cl = m_hold_l[0] * 16; cr = m_hold_r[0] * 16; end
        end else if (op == 2'd0 && ch == 3'd6) begin
            if (mix_en[1]) begin cl = m_hold_l[1] >>> 2; cr = m_hold_r[1] >>> 2; end
        end else if (fm_on(alg, s1_enters, s2_enters, s4_enters)) begin
            if (rl[1]) cl = op_result;
            if (rl[0]) cr = op_result;
        end
        ovl = 1'b0; ovr = 1'b0;
        if (en && z) begin
            ovl = (sat16(m_acc_l) != m_acc_l);
            ovr = (sat16(m_acc_r) != m_acc_r);
            e.l = sat16(m_acc_l);
            e.r = sat16(m_acc_r);
            exp_q.push_back(e);
            m_acc_l = cl; m_acc_r = cr;
        end else if (en) begin
            m_acc_l += cl; m_acc_r += cr;
        end
        if (ovl) m_clip_l = 1'b1; else if (clip_clr) m_clip_l = 1'b0;
        if (ovr) m_clip_r = 1'b1; else if (clip_clr) m_clip_r = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (ext_stb[i]) begin
                m_hold_l[i] = $signed(ext_l[16*i +: 16]);
                m_hold_r[i] = $signed(ext_r[16*i +: 16]);
            end
        end
        exp_stb = en && z;
        @(posedge clk); #1;
        total_cnt++;
        if (sample_stb !== exp_stb)
            $display("FAIL sample_stb op%0d ch%0d: got %0b expected %0b", op, ch, sample_stb, exp_stb);
        else pass_cnt++;
        if (exp_stb && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_left = e.l; m_right = e.r;
        end
        total_cnt++;
        if (left !== m_left || right !== m_right)
            $display("FAIL outputs op%0d ch%0d: got %0d/%0d expected %0d/%0d", op, ch, left, right, m_left, m_right);
        else pass_cnt++;
        total_cnt++;
        if (clip_l !== m_clip_l || clip_r !== m_clip_r)
            $display("FAIL clip op%0d ch%0d: got %0b/%0b expected %0b/%0b", op, ch, clip_l, clip_r, m_clip_l, m_clip_r);
        else pass_cnt++;
        ext_stb = 2'b00; clip_clr = 1'b0;
    endtask

    // Slot index s = op*6 + channel position; channels are 0,1,2,4,5,6.
    task automatic run_slots(input int from, input int to);
        int chi;
        for (int s = from; s <= to; s++) begin
            chi = s % 6;
            step(2'(s / 6), 3'((chi < 3) ? chi : chi + 1), (s == 0), 1'b1);
        end
    endtask

    task automatic test_reset();
        clk_en = 1'b0; op_result = 14'sd0; rl = 2'b11; zero = 1'b0;
        s1_enters = 1'b0; s2_enters = 1'b0; s4_enters = 1'b0; alg = 3'd7;
        cur_ch = 3'd0; cur_op = 2'd0; ext_l = 32'd0; ext_r = 32'd0; ext_stb = 2'b00;
        mix_en = 2'b00; clip_clr = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        total_cnt++;
        if (left !== 0 || right !== 0) $display("FAIL reset_out: got %0d/%0d expected 0/0", left, right);
        else pass_cnt++;
        total_cnt++;
        if (sample_stb !== 1'b0) $display("FAIL reset_stb: got %0b expected 0", sample_stb);
        else pass_cnt++;
        total_cnt++;
        if (clip_l !== 1'b0 || clip_r !== 1'b0) $display("FAIL reset_clip: got %0b/%0b expected 0/0", clip_l, clip_r);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_fm_sum();
        alg = 3'd7; rl = 2'b11; op_result = 14'sd100; mix_en = 2'b00;
        run_slots(0, 23);
        run_slots(0, 23);
        run_slots(0, 0);
        total_cnt++;
        if (left !== 2200 || right !== 2200) $display("FAIL fm_sum: got %0d/%0d expected 2200/2200", left, right);
        else pass_cnt++;
        run_slots(1, 1);
        total_cnt++;
        if (sample_stb !== 1'b0) $display("FAIL fm_stb_single: got %0b expected 0", sample_stb);
        else pass_cnt++;
        alg = 3'd0; rl = 2'b10;
        run_slots(2, 23);
        run_slots(0, 0);
        total_cnt++;
        if (left !== 800 || right !== 200) $display("FAIL fm_alg0_rl: got %0d/%0d expected 800/200", left, right);
        else pass_cnt++;
    endtask

    task automatic test_ext();
        alg = 3'd7; rl = 2'b11; op_result = 14'sd0; mix_en = 2'b01;
        ext_l = {16'hFF9C, 16'h0100};
        ext_r = {16'h0040, 16'hFFF0};
        ext_stb = 2'b11;
        step(2'd0, 3'd1, 1'b1, 1'b0);
        run_slots(1, 23);
        run_slots(0, 0);
        total_cnt++;
        if (left !== 4096 || right !== -256) $display("FAIL ext_scale: got %0d/%0d expected 4096/-256", left, right);
        else pass_cnt++;
        run_slots(1, 23);
        run_slots(0, 0);
        total_cnt++;
        if (left !== 4096) $display("FAIL ext_repeat: got %0d expected 4096", left);
        else pass_cnt++;
        mix_en = 2'b11;
        run_slots(1, 23);
        run_slots(0, 0);
        total_cnt++;
        if (left !== 4071 || right !== -240) $display("FAIL ext_both: got %0d/%0d expected 4071/-240", left, right);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        mix_en = 2'b01;
        run_slots(1, 1);
        ext_l[15:0] = 16'h0200;
        ext_r[15:0] = 16'h0010;
        ext_stb = 2'b01;
        run_slots(2, 2);
        run_slots(3, 23);
        run_slots(0, 0);
        total_cnt++;
        if (left !== 4096 || right !== -256) $display("FAIL b2b_old: got %0d/%0d expected 4096/-256", left, right);
        else pass_cnt++;
        run_slots(1, 23);
        run_slots(0, 0);
        total_cnt++;
        if (left !== 8192 || right !== 256) $display("FAIL b2b_new: got %0d/%0d expected 8192/256", left, right);
        else pass_cnt++;
    endtask

    task automatic test_clip();
        mix_en = 2'b00; op_result = 14'sd8191; rl = 2'b11;
        run_slots(1, 23);
        run_slots(0, 0);
        total_cnt++;
        if (left !== 32767 || clip_l !== 1'b1) $display("FAIL clip_pos: got %0d/%0b expected 32767/1", left, clip_l);
        else pass_cnt++;
        op_result = 14'sd0; clip_clr = 1'b1;
        run_slots(1, 1);
        total_cnt++;
        if (clip_l !== 1'b0 || clip_r !== 1'b0) $display("FAIL clip_clr: got %0b/%0b expected 0/0", clip_l, clip_r);
        else pass_cnt++;
        op_result = -14'sd8192; rl = 2'b01;
        run_slots(2, 23);
        clip_clr = 1'b1;
        run_slots(0, 0);
        total_cnt++;
        if (right !== -32768 || clip_r !== 1'b1 || clip_l !== 1'b0)
            $display("FAIL clip_neg_set_wins: got %0d/%0b/%0b expected -32768/1/0", right, clip_r, clip_l);
        else pass_cnt++;
    endtask

    task automatic test_freeze();
        op_result = 14'sd100; rl = 2'b11;
        for (int k = 0; k < 3; k++) begin
            op_result = 14'($urandom_range(0, 8000));
            ext_l[15:0] = 16'h0010; ext_stb = 2'b01;
            clip_clr = (k == 1);
            step(2'd0, 3'd1, 1'b1, 1'b0);
        end
        total_cnt++;
        if (right !== -32768 || sample_stb !== 1'b0 || clip_r !== 1'b0)
            $display("FAIL freeze: got %0d/%0b/%0b expected -32768/0/0", right, sample_stb, clip_r);
        else pass_cnt++;
        op_result = 14'sd100; mix_en = 2'b01;
        run_slots(1, 23);
        run_slots(0, 0);
    endtask

    task automatic test_reset_midframe();
        alg = 3'd7; rl = 2'b11; op_result = 14'sd100; mix_en = 2'b11;
        run_slots(1, 8);
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        total_cnt++;
        if (left !== 0 || right !== 0 || sample_stb !== 1'b0 || clip_l !== 1'b0 || clip_r !== 1'b0)
            $display("FAIL midreset: got %0d/%0d stb %0b expected 0/0 stb 0", left, right, sample_stb);
        else pass_cnt++;
        run_slots(9, 23);
        run_slots(0, 0);
        total_cnt++;
        if (left !== 1500 || right !== 1500) $display("FAIL midreset_sum: got %0d/%0d expected 1500/1500", left, right);
        else pass_cnt++;
        run_slots(1, 23);
        run_slots(0, 0);
    endtask

    initial begin
        test_reset();
        test_fm_sum();
        test_ext();
        test_back_to_back();
        test_clip();
        test_freeze();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
